// File: rtl/tlb_op_ctrl.sv
// rtl/tlb_op_ctrl.sv - multi-cycle sequencer for TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB
// Define TLB_FILL_LFSR_EN to pick FILL victims from a Galois LFSR instead of a round-robin counter.

module tlb_op_ctrl #(
  parameter int TLBNUM = 16,
  localparam int IW = $clog2(TLBNUM)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          op_valid,
  output logic          op_ready,
  input  logic [2:0]    op_code,
  input  logic [4:0]    inv_op,
  input  logic [9:0]    inv_asid,
  input  logic [18:0]   inv_vppn,
  input  logic [9:0]    csr_asid,
  input  logic [18:0]   csr_ehi_vppn,
  input  logic [IW-1:0] csr_idx,
  input  logic          csr_ne,
  output logic [18:0]   s1_vppn,
  output logic [9:0]    s1_asid,
  input  logic          s1_found,
  input  logic [IW-1:0] s1_index,
  output logic [IW-1:0] tlb_r_index,
  input  logic          tlb_r_e,
  input  logic          tlb_r_g,
  input  logic [9:0]    tlb_r_asid,
  input  logic [18:0]   tlb_r_vppn,
  output logic          tlb_we,
  output logic [IW-1:0] tlb_w_index,
  output logic          tlb_w_e,
  output logic          tlb_inv_we,
  output logic [IW-1:0] tlb_inv_index,
  output logic          done,
  output logic          srch_hit,
  output logic [IW-1:0] srch_index,
  output logic          rd_e,
  output logic          inv_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SRCH,
    S_RD_REQ,
    S_RD_CAP,
    S_WRITE,
    S_INV_SCAN,
    S_DONE
  } state_t;

  // Scan counter: reads issued while cnt < TLBNUM, compares while 1 <= cnt <= TLBNUM,
  // cnt == TLBNUM+1 lets the last registered clear strobe drain.
  localparam logic [IW:0] CNT_LAST_CMP = (IW+1)'(TLBNUM);
  localparam logic [IW:0] CNT_END      = (IW+1)'(TLBNUM + 1);

`ifdef TLB_FILL_LFSR_EN
  function automatic logic [IW-1:0] lfsr_taps(input int n);
    logic [31:0] t;
    case (n)
      2:       t = 32'h0003;
      3:       t = 32'h0006;
      4:       t = 32'h000C;
      5:       t = 32'h0014;
      6:       t = 32'h0030;
      7:       t = 32'h0060;
      8:       t = 32'h00B8;
      9:       t = 32'h0110;
      10:      t = 32'h0240;
      11:      t = 32'h0500;
      12:      t = 32'h0829;
      13:      t = 32'h100D;
      14:      t = 32'h2015;
      15:      t = 32'h6000;
      16:      t = 32'hD008;
      default: t = 32'h0003;
    endcase
    return IW'(t);
  endfunction
  localparam logic [IW-1:0] LFSR_TAPS = lfsr_taps(IW);
  localparam logic [IW-1:0] FILL_SEED = IW'(1);
`else
  localparam logic [IW-1:0] FILL_SEED = '0;
`endif

  state_t        state_q, state_d;
  logic [IW:0]   cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [4:0]    inv_op_q, inv_op_d;
  logic [9:0]    inv_asid_q, inv_asid_d;
  logic [18:0]   inv_vppn_q, inv_vppn_d;
  logic [IW-1:0] fill_ptr_q, fill_ptr_d;
  logic [18:0]   s1_vppn_q, s1_vppn_d;
  logic [9:0]    s1_asid_q, s1_asid_d;
  logic          we_q, we_d;
  logic [IW-1:0] w_index_q, w_index_d;
  logic          w_e_q, w_e_d;
  logic          inv_we_q, inv_we_d;
  logic [IW-1:0] inv_index_q, inv_index_d;
  logic          done_q, done_d;
  logic          srch_hit_q, srch_hit_d;
  logic [IW-1:0] srch_index_q, srch_index_d;
  logic          rd_e_q, rd_e_d;
  logic          inv_err_q, inv_err_d;

  logic          asid_match;
  logic          vppn_match;
  logic          op_hit;

  always_comb begin
    asid_match = (tlb_r_asid == inv_asid_q);
    vppn_match = (tlb_r_vppn == inv_vppn_q);
    case (inv_op_q)
      5'd0, 5'd1: op_hit = 1'b1;
      5'd2:       op_hit = tlb_r_g;
      5'd3:       op_hit = !tlb_r_g;
      5'd4:       op_hit = !tlb_r_g && asid_match;
      5'd5:       op_hit = !tlb_r_g && asid_match && vppn_match;
      5'd6:       op_hit = (tlb_r_g || asid_match) && vppn_match;
      default:    op_hit = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    inv_op_d     = inv_op_q;
    inv_asid_d   = inv_asid_q;
    inv_vppn_d   = inv_vppn_q;
    s1_vppn_d    = '0;
    s1_asid_d    = '0;
    we_d         = 1'b0;
    w_index_d    = '0;
    w_e_d        = 1'b0;
    inv_we_d     = 1'b0;
    inv_index_d  = '0;
    done_d       = 1'b0;
    inv_err_d    = 1'b0;
    srch_hit_d   = srch_hit_q;
    srch_index_d = srch_index_q;
    rd_e_d       = rd_e_q;
`ifdef TLB_FILL_LFSR_EN
    fill_ptr_d   = {1'b0, fill_ptr_q[IW-1:1]} ^ (fill_ptr_q[0] ? LFSR_TAPS : '0);
`else
    fill_ptr_d   = fill_ptr_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (op_valid) begin
          case (op_code)
            3'd0: begin
              s1_vppn_d = csr_ehi_vppn;
              s1_asid_d = csr_asid;
              state_d   = S_SRCH;
            end
            3'd1: begin
              idx_d   = csr_idx;
              state_d = S_RD_REQ;
            end
            3'd2: begin
              we_d      = 1'b1;
              w_index_d = csr_idx;
              w_e_d     = !csr_ne;
              state_d   = S_WRITE;
            end
            3'd3: begin
              we_d      = 1'b1;
              w_index_d = fill_ptr_q;
              w_e_d     = !csr_ne;
              state_d   = S_WRITE;
`ifndef TLB_FILL_LFSR_EN
              fill_ptr_d = fill_ptr_q + IW'(1);
`endif
            end
            3'd4: begin
              if (inv_op > 5'd6) begin
                inv_err_d = 1'b1;
                done_d    = 1'b1;
                state_d   = S_DONE;
              end else begin
                inv_op_d   = inv_op;
                inv_asid_d = inv_asid;
                inv_vppn_d = inv_vppn;
                cnt_d      = '0;
                state_d    = S_INV_SCAN;
              end
            end
            default: begin
              done_d  = 1'b1;
              state_d = S_DONE;
            end
          endcase
        end
      end
      S_SRCH: begin
        srch_hit_d   = s1_found;
        srch_index_d = s1_index;
        done_d       = 1'b1;
        state_d      = S_DONE;
      end
      S_RD_REQ: state_d = S_RD_CAP;
      S_RD_CAP: begin
        rd_e_d  = tlb_r_e;
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      S_WRITE: begin
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      S_INV_SCAN: begin
        cnt_d = cnt_q + (IW+1)'(1);
        // Read data in this cycle belongs to the index issued last cycle.
        if ((cnt_q != '0) && (cnt_q <= CNT_LAST_CMP) && tlb_r_e && op_hit) begin
          inv_we_d    = 1'b1;
          inv_index_d = cnt_q[IW-1:0] - IW'(1);
        end
        if (cnt_q == CNT_END) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      inv_op_q     <= '0;
      inv_asid_q   <= '0;
      inv_vppn_q   <= '0;
      fill_ptr_q   <= FILL_SEED;
      s1_vppn_q    <= '0;
      s1_asid_q    <= '0;
      we_q         <= 1'b0;
      w_index_q    <= '0;
      w_e_q        <= 1'b0;
      inv_we_q     <= 1'b0;
      inv_index_q  <= '0;
      done_q       <= 1'b0;
      srch_hit_q   <= 1'b0;
      srch_index_q <= '0;
      rd_e_q       <= 1'b0;
      inv_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      inv_op_q     <= inv_op_d;
      inv_asid_q   <= inv_asid_d;
      inv_vppn_q   <= inv_vppn_d;
      fill_ptr_q   <= fill_ptr_d;
      s1_vppn_q    <= s1_vppn_d;
      s1_asid_q    <= s1_asid_d;
      we_q         <= we_d;
      w_index_q    <= w_index_d;
      w_e_q        <= w_e_d;
      inv_we_q     <= inv_we_d;
      inv_index_q  <= inv_index_d;
      done_q       <= done_d;
      srch_hit_q   <= srch_hit_d;
      srch_index_q <= srch_index_d;
      rd_e_q       <= rd_e_d;
      inv_err_q    <= inv_err_d;
    end
  end

  always_comb begin
    tlb_r_index = '0;
    if (state_q == S_RD_REQ) begin
      tlb_r_index = idx_q;
    end else if ((state_q == S_INV_SCAN) && !cnt_q[IW]) begin
      tlb_r_index = cnt_q[IW-1:0];
    end
  end

  assign op_ready      = (state_q == S_IDLE);
  assign s1_vppn       = s1_vppn_q;
  assign s1_asid       = s1_asid_q;
  assign tlb_we        = we_q;
  assign tlb_w_index   = w_index_q;
  assign tlb_w_e       = w_e_q;
  assign tlb_inv_we    = inv_we_q;
  assign tlb_inv_index = inv_index_q;
  assign done          = done_q;
  assign srch_hit      = srch_hit_q;
  assign srch_index    = srch_index_q;
  assign rd_e          = rd_e_q;
  assign inv_err       = inv_err_q;

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// tb/tb_tlb_op_ctrl.sv - randomized bench for tlb_op_ctrl with a behavioural TLB and reference model

module tb_tlb_op_ctrl;
  localparam int TLBNUM = 16;
  localparam int IW = $clog2(TLBNUM);

  logic          clk = 1'b0;
  logic          reset;
  logic          op_valid;
  logic          op_ready;
  logic [2:0]    op_code;
  logic [4:0]    inv_op;
  logic [9:0]    inv_asid;
  logic [18:0]   inv_vppn;
  logic [9:0]    csr_asid;
  logic [18:0]   csr_ehi_vppn;
  logic [IW-1:0] csr_idx;
  logic          csr_ne;
  logic [18:0]   s1_vppn;
  logic [9:0]    s1_asid;
  logic          s1_found;
  logic [IW-1:0] s1_index;
  logic [IW-1:0] tlb_r_index;
  logic          tlb_r_e;
  logic          tlb_r_g;
  logic [9:0]    tlb_r_asid;
  logic [18:0]   tlb_r_vppn;
  logic          tlb_we;
  logic [IW-1:0] tlb_w_index;
  logic          tlb_w_e;
  logic          tlb_inv_we;
  logic [IW-1:0] tlb_inv_index;
  logic          done;
  logic          srch_hit;
  logic [IW-1:0] srch_index;
  logic          rd_e;
  logic          inv_err;

  tlb_op_ctrl #(.TLBNUM(TLBNUM)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
    .inv_op(inv_op), .inv_asid(inv_asid), .inv_vppn(inv_vppn), .csr_asid(csr_asid),
    .csr_ehi_vppn(csr_ehi_vppn), .csr_idx(csr_idx), .csr_ne(csr_ne), .s1_vppn(s1_vppn),
    .s1_asid(s1_asid), .s1_found(s1_found), .s1_index(s1_index), .tlb_r_index(tlb_r_index),
    .tlb_r_e(tlb_r_e), .tlb_r_g(tlb_r_g), .tlb_r_asid(tlb_r_asid), .tlb_r_vppn(tlb_r_vppn),
    .tlb_we(tlb_we), .tlb_w_index(tlb_w_index), .tlb_w_e(tlb_w_e), .tlb_inv_we(tlb_inv_we),
    .tlb_inv_index(tlb_inv_index), .done(done), .srch_hit(srch_hit), .srch_index(srch_index),
    .rd_e(rd_e), .inv_err(inv_err)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  bit        mem_e[TLBNUM];
  bit        mem_g[TLBNUM];
  bit [9:0]  mem_asid[TLBNUM];
  bit [18:0] mem_vppn[TLBNUM];
  logic [IW-1:0] last_r_idx = '0;

  int            lat;
  int            we_cnt;
  int            inv_cnt;
  logic [IW-1:0] we_idx;
  logic          we_e;
  logic [TLBNUM-1:0] inv_mask;
  logic          both_strobe;
  logic [9:0]    c1_s1_asid;
  logic [18:0]   c1_s1_vppn;
  logic [IW-1:0] c1_r_index;
  logic          res_hit;
  logic [IW-1:0] res_idx;
  logic          res_rd_e;
  logic          res_inv_err;
  logic          ready_after;
  logic          done_after;

  // One clock: advance past the edge, then play the TLB array (sync read, write/clear strobes).
  task automatic tick();
    @(posedge clk);
    #1;
    tlb_r_e    = mem_e[last_r_idx];
    tlb_r_g    = mem_g[last_r_idx];
    tlb_r_asid = mem_asid[last_r_idx];
    tlb_r_vppn = mem_vppn[last_r_idx];
    last_r_idx = tlb_r_index;
    if (tlb_we) mem_e[tlb_w_index] = tlb_w_e;
    if (tlb_inv_we) mem_e[tlb_inv_index] = 1'b0;
  endtask

  task automatic scramble_operands();
    csr_idx      = IW'($urandom);
    csr_ne       = 1'($urandom);
    csr_asid     = 10'($urandom);
    csr_ehi_vppn = 19'($urandom);
    inv_op       = 5'($urandom);
    inv_asid     = 10'($urandom);
    inv_vppn     = 19'($urandom);
    op_code      = 3'($urandom);
  endtask

  task automatic do_op(input logic [2:0] code);
    int w;
    lat = -1; we_cnt = 0; inv_cnt = 0; inv_mask = '0; both_strobe = 1'b0;
    w = 0;
    @(negedge clk);
    while (!op_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    op_valid = 1'b1;
    op_code  = code;
    tick();
    op_valid = 1'b0;
    c1_s1_asid = s1_asid;
    c1_s1_vppn = s1_vppn;
    c1_r_index = tlb_r_index;
    scramble_operands();
    for (int c = 1; c <= 200; c++) begin
      if (c > 1) tick();
      if (tlb_we) begin we_cnt++; we_idx = tlb_w_index; we_e = tlb_w_e; end
      if (tlb_inv_we) begin inv_cnt++; inv_mask[tlb_inv_index] = 1'b1; end
      if (tlb_we && tlb_inv_we) both_strobe = 1'b1;
      if (done) begin
        lat = c; res_hit = srch_hit; res_idx = srch_index; res_rd_e = rd_e; res_inv_err = inv_err;
        break;
      end
    end
    tick();
    ready_after = op_ready;
    done_after  = done;
  endtask

  function automatic logic [TLBNUM-1:0] e_mask();
    logic [TLBNUM-1:0] m;
    for (int i = 0; i < TLBNUM; i++) m[i] = mem_e[i];
    return m;
  endfunction

  function automatic logic [TLBNUM-1:0] inv_ref(input int op, input logic [9:0] a, input logic [18:0] v);
    logic [TLBNUM-1:0] m;
    bit am, vm, g, hit;
    m = '0;
    for (int i = 0; i < TLBNUM; i++) begin
      am = (mem_asid[i] == a);
      vm = (mem_vppn[i] == v);
      g  = mem_g[i];
      case (op)
        0, 1:    hit = 1'b1;
        2:       hit = g;
        3:       hit = !g;
        4:       hit = !g && am;
        5:       hit = !g && am && vm;
        6:       hit = (g || am) && vm;
        default: hit = 1'b0;
      endcase
      m[i] = mem_e[i] && hit;
    end
    return m;
  endfunction

  task automatic rand_mem();
    for (int i = 0; i < TLBNUM; i++) begin
      mem_e[i]    = ($urandom_range(0, 3) != 0);
      mem_g[i]    = 1'($urandom);
      mem_asid[i] = ($urandom_range(0, 1) != 0) ? 10'h12 : 10'h34;
      mem_vppn[i] = ($urandom_range(0, 1) != 0) ? 19'h100 : 19'h200;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; op_valid = 1'b0; op_code = '0; inv_op = '0; inv_asid = '0; inv_vppn = '0;
    csr_asid = '0; csr_ehi_vppn = '0; csr_idx = '0; csr_ne = 1'b0; s1_found = 1'b0; s1_index = '0;
    tlb_r_e = 1'b0; tlb_r_g = 1'b0; tlb_r_asid = '0; tlb_r_vppn = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    total_cnt++;
    if (op_ready !== 1'b1) $display("FAIL reset_op_ready got=%b exp=1", op_ready); else pass_cnt++;
    total_cnt++;
    if ({done, tlb_we, tlb_inv_we, srch_hit, srch_index, rd_e, inv_err, s1_asid, s1_vppn,
         tlb_w_index, tlb_w_e, tlb_inv_index, tlb_r_index} !== '0)
      $display("FAIL reset_outputs_zero got done=%b we=%b inv_we=%b hit=%b rd_e=%b inv_err=%b exp all 0",
               done, tlb_we, tlb_inv_we, srch_hit, rd_e, inv_err);
    else pass_cnt++;
  endtask

  task automatic test_srch();
    logic f; logic [IW-1:0] si; logic [9:0] a; logic [18:0] v;
    for (int it = 0; it < 6; it++) begin
      f  = (it == 0) ? 1'b1 : 1'($urandom);
      si = (it == 0) ? IW'(5) : IW'($urandom);
      a  = 10'($urandom);
      v  = 19'($urandom);
      s1_found = f; s1_index = si; csr_asid = a; csr_ehi_vppn = v;
      do_op(3'd0);
      total_cnt++;
      if (lat !== 2) $display("FAIL srch_latency it=%0d got=%0d exp=2", it, lat); else pass_cnt++;
      total_cnt++;
      if ({res_hit, res_idx} !== {f, si})
        $display("FAIL srch_result it=%0d got=%b/%0d exp=%b/%0d", it, res_hit, res_idx, f, si);
      else pass_cnt++;
      total_cnt++;
      if ({c1_s1_asid, c1_s1_vppn} !== {a, v})
        $display("FAIL srch_key it=%0d got=%h/%h exp=%h/%h", it, c1_s1_asid, c1_s1_vppn, a, v);
      else pass_cnt++;
      total_cnt++;
      if ((we_cnt + inv_cnt) !== 0 || ready_after !== 1'b1 || done_after !== 1'b0)
        $display("FAIL srch_side it=%0d strobes=%0d ready_after=%b done_after=%b exp 0/1/0",
                 it, we_cnt + inv_cnt, ready_after, done_after);
      else pass_cnt++;
    end
  endtask

  task automatic test_rd();
    logic [IW-1:0] idx; bit exp_e;
    rand_mem();
    for (int it = 0; it < 6; it++) begin
      idx = (it == 0) ? IW'(3) : IW'($urandom);
      if (it == 0) mem_e[3] = 1'b1;
      exp_e = mem_e[idx];
      csr_idx = idx;
      do_op(3'd1);
      total_cnt++;
      if (lat !== 3) $display("FAIL rd_latency it=%0d got=%0d exp=3", it, lat); else pass_cnt++;
      total_cnt++;
      if (c1_r_index !== idx) $display("FAIL rd_index it=%0d got=%0d exp=%0d", it, c1_r_index, idx); else pass_cnt++;
      total_cnt++;
      if (res_rd_e !== exp_e) $display("FAIL rd_e it=%0d got=%b exp=%b", it, res_rd_e, exp_e); else pass_cnt++;
      total_cnt++;
      if ((we_cnt + inv_cnt) !== 0) $display("FAIL rd_strobes it=%0d got=%0d exp=0", it, we_cnt + inv_cnt); else pass_cnt++;
    end
  endtask

  task automatic test_wr();
    logic [IW-1:0] idx; logic ne;
    for (int it = 0; it < 5; it++) begin
      idx = (it == 0) ? IW'(7) : IW'($urandom);
      ne  = (it == 0) ? 1'b1 : 1'($urandom);
      csr_idx = idx; csr_ne = ne;
      do_op(3'd2);
      total_cnt++;
      if (lat !== 2) $display("FAIL wr_latency it=%0d got=%0d exp=2", it, lat); else pass_cnt++;
      total_cnt++;
      if (we_cnt !== 1 || inv_cnt !== 0)
        $display("FAIL wr_pulses it=%0d got we=%0d inv=%0d exp 1/0", it, we_cnt, inv_cnt);
      else pass_cnt++;
      total_cnt++;
      if ({we_idx, we_e} !== {idx, !ne})
        $display("FAIL wr_data it=%0d got=%0d/%b exp=%0d/%b", it, we_idx, we_e, idx, !ne);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back_fill();
    int exp_ptr = 0;
    for (int it = 0; it < TLBNUM + 3; it++) begin
      csr_idx = IW'($urandom);
      csr_ne  = 1'b0;
      do_op(3'd3);
      total_cnt++;
      if (lat !== 2 || we_cnt !== 1 || ready_after !== 1'b1)
        $display("FAIL fill_shape it=%0d got lat=%0d we=%0d ready_after=%b exp 2/1/1", it, lat, we_cnt, ready_after);
      else pass_cnt++;
      total_cnt++;
      if (we_idx !== IW'(exp_ptr)) $display("FAIL fill_index it=%0d got=%0d exp=%0d", it, we_idx, exp_ptr); else pass_cnt++;
      exp_ptr = (exp_ptr + 1) % TLBNUM;
    end
  endtask

  task automatic run_inv(input int op, input logic [9:0] a, input logic [18:0] v, input string tag);
    logic [TLBNUM-1:0] exp_m, pre_m;
    exp_m = inv_ref(op, a, v);
    pre_m = e_mask();
    inv_op = 5'(op); inv_asid = a; inv_vppn = v;
    do_op(3'd4);
    total_cnt++;
    if (lat !== TLBNUM + 3) $display("FAIL inv_latency %s op=%0d got=%0d exp=%0d", tag, op, lat, TLBNUM + 3); else pass_cnt++;
    total_cnt++;
    if (inv_mask !== exp_m || inv_cnt !== $countones(exp_m))
      $display("FAIL inv_cleared %s op=%0d got=%h(%0d) exp=%h(%0d)", tag, op, inv_mask, inv_cnt, exp_m, $countones(exp_m));
    else pass_cnt++;
    total_cnt++;
    if (we_cnt !== 0 || both_strobe !== 1'b0 || res_inv_err !== 1'b0 || e_mask() !== (pre_m & ~exp_m))
      $display("FAIL inv_side %s op=%0d we=%0d both=%b err=%b emask=%h exp 0/0/0/%h",
               tag, op, we_cnt, both_strobe, res_inv_err, e_mask(), pre_m & ~exp_m);
    else pass_cnt++;
  endtask

  task automatic test_invtlb();
    for (int i = 0; i < TLBNUM; i++) begin
      mem_e[i] = 1'b0; mem_g[i] = 1'b0; mem_asid[i] = 10'h0; mem_vppn[i] = 19'h0;
    end
    mem_e[2] = 1'b1; mem_g[2] = 1'b0; mem_asid[2] = 10'h12; mem_vppn[2] = 19'h100;
    mem_e[9] = 1'b1; mem_g[9] = 1'b1; mem_asid[9] = 10'h12; mem_vppn[9] = 19'h100;
    run_inv(5, 10'h12, 19'h100, "directed");
    total_cnt++;
    if (inv_mask !== 16'h0004) $display("FAIL inv_directed_mask got=%h exp=0004", inv_mask); else pass_cnt++;
    for (int op = 0; op <= 6; op++) begin
      for (int r = 0; r < 2; r++) begin
        rand_mem();
        run_inv(op, ($urandom_range(0, 1) != 0) ? 10'h12 : 10'h34,
                ($urandom_range(0, 1) != 0) ? 19'h100 : 19'h200, "random");
      end
    end
  endtask

  task automatic test_inv_err_and_nop();
    for (int it = 0; it < 4; it++) begin
      inv_op = 5'($urandom_range(7, 31));
      do_op(3'd4);
      total_cnt++;
      if (lat !== 1 || res_inv_err !== 1'b1 || (we_cnt + inv_cnt) !== 0 || done_after !== 1'b0)
        $display("FAIL inv_err it=%0d got lat=%0d err=%b strobes=%0d done_after=%b exp 1/1/0/0",
                 it, lat, res_inv_err, we_cnt + inv_cnt, done_after);
      else pass_cnt++;
    end
    for (int c = 5; c <= 7; c++) begin
      do_op(3'(c));
      total_cnt++;
      if (lat !== 1 || res_inv_err !== 1'b0 || (we_cnt + inv_cnt) !== 0 || ready_after !== 1'b1)
        $display("FAIL nop code=%0d got lat=%0d err=%b strobes=%0d ready_after=%b exp 1/0/0/1",
                 c, lat, res_inv_err, we_cnt + inv_cnt, ready_after);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_scan();
    int seen_done = 0;
    int seen_strobe = 0;
    for (int i = 0; i < TLBNUM; i++) mem_e[i] = 1'b1;
    inv_op = 5'd0;
    @(negedge clk);
    op_valid = 1'b1;
    op_code  = 3'd4;
    tick();
    op_valid = 1'b0;
    for (int c = 2; c <= 6; c++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total_cnt++;
    if (op_ready !== 1'b1 || tlb_inv_we !== 1'b0 || tlb_we !== 1'b0 || done !== 1'b0)
      $display("FAIL midreset_state got ready=%b inv_we=%b we=%b done=%b exp 1/0/0/0", op_ready, tlb_inv_we, tlb_we, done);
    else pass_cnt++;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (done) seen_done++;
      if (tlb_inv_we || tlb_we) seen_strobe++;
    end
    total_cnt++;
    if (seen_done !== 0 || seen_strobe !== 0)
      $display("FAIL midreset_quiet got done=%0d strobes=%0d exp 0/0", seen_done, seen_strobe);
    else pass_cnt++;
    s1_found = 1'b1; s1_index = IW'(11);
    do_op(3'd0);
    total_cnt++;
    if (lat !== 2 || res_hit !== 1'b1 || res_idx !== IW'(11))
      $display("FAIL midreset_recover got lat=%0d hit=%b idx=%0d exp 2/1/11", lat, res_hit, res_idx);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_srch();
    test_rd();
    test_wr();
    test_back_to_back_fill();
    test_invtlb();
    test_inv_err_and_nop();
    test_reset_mid_scan();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/tlb_op_ctrl.md
# tlb_op_ctrl

Multi-cycle sequencer for the TLB maintenance instructions TLBSRCH, TLBRD, TLBWR, TLBFILL and INVTLB. It sits between the execute-stage CSR/exception logic and the TLB array, and has exclusive use of the TLB read/write/invalidate ports and the s1 search port while an operation runs. It accepts one operation at a time over a valid/ready handshake and returns a one-cycle `done` pulse with results. INVTLB runs as a pipelined scan over all entries. TLBFILL chooses its victim entry internally.

## Interface
- `TLBNUM`, 16, number of TLB entries (power of two, ≥4); IW = $clog2(TLBNUM)
- `clk` in 1, the single clock
- `reset` in 1, synchronous, active-high
- `op_valid` in 1, operation request
- `op_ready` out 1, high only in IDLE
- `op_code` in 3, 0 SRCH, 1 RD, 2 WR, 3 FILL, 4 INVTLB; 5–7 treated as NOP
- `inv_op` in 5, INVTLB op field
- `inv_asid` in 10, INVTLB ASID operand
- `inv_vppn` in 19, INVTLB VA[31:13]
- `csr_asid` in 10, current ASID.ASID
- `csr_ehi_vppn` in 19, TLBEHI.VPPN
- `csr_idx` in IW, TLBIDX.Index
- `csr_ne` in 1, TLBIDX.NE
- `s1_vppn` out 19, search VPPN
- `s1_asid` out 10, search ASID
- `s1_found` in 1, combinational search hit
- `s1_index` in IW, combinational search index
- `tlb_r_index` out IW, read address; synchronous read, data valid next cycle
- `tlb_r_e` in 1, E bit of the entry read
- `tlb_r_g` in 1, G bit of the entry read
- `tlb_r_asid` in 10, ASID of the entry read
- `tlb_r_vppn` in 19, VPPN of the entry read
- `tlb_we` out 1, full-entry write strobe
- `tlb_w_index` out IW, write address
- `tlb_w_e` out 1, E value to write (= ~csr_ne)
- `tlb_inv_we` out 1, clear-E strobe
- `tlb_inv_index` out IW, entry to clear
- `done` out 1, one-cycle completion pulse
- `srch_hit` out 1, TLBSRCH result; held until the next `done`
- `srch_index` out IW, TLBSRCH index; held until the next `done`
- `rd_e` out 1, TLBRD entry valid; held until the next `done`
- `inv_err` out 1, asserted with `done` when `inv_op` > 6

## Operation
- States: IDLE, SRCH, RD_REQ, RD_CAP, WRITE, INV_SCAN, DONE.
- Handshake: an operation is accepted on a clock edge where `op_valid` and `op_ready` are both high. Operands are registered at acceptance. `op_valid` while busy is ignored.
- **SRCH** drives `s1_vppn`=`csr_ehi_vppn` and `s1_asid`=`csr_asid` for one cycle, then captures `s1_found` and `s1_index`, then goes to DONE.
- **RD**:
  - RD_REQ drives `tlb_r_index`=`csr_idx`.
  - RD_CAP captures `rd_e`=`tlb_r_e`, then goes to DONE.
- **WR** spends one WRITE cycle with `tlb_we`=1 and `tlb_w_index`=`csr_idx`.
- **FILL** is the same as WR except `tlb_w_index`=`fill_ptr`.
- **INVTLB**:
  - If `inv_op` > 6, go straight to DONE with `inv_err`=1 and no TLB writes.
  - Otherwise INV_SCAN issues reads for index 0..TLBNUM-1 on consecutive cycles. It compares index i-1 in the cycle it issues i, then runs one extra compare cycle. The scan counter is IW+1 bits wide.
  - An entry is cleared (`tlb_inv_we`=1, `tlb_inv_index`=i-1) when `tlb_r_e`=1 and the op condition holds:
    - op 0/1: all entries
    - op 2: G=1
    - op 3: G=0
    - op 4: G=0 && asid match
    - op 5: G=0 && asid match && vppn match
    - op 6: (G=1 || asid match) && vppn match
- DONE asserts `done` for one cycle, then returns to IDLE.
- Codes 5–7 go to DONE with no side effects.
- Only one of `tlb_we` and `tlb_inv_we` is asserted in any cycle.

## Timing
- Reset values: all outputs 0; state IDLE, so `op_ready`=1 after reset; `fill_ptr`=0 (without macro) or seed 1 (with macro).
- Latency from the acceptance edge to the cycle in which `done`=1:
  - SRCH: 2
  - RD: 3
  - WR/FILL: 2
  - INVTLB: TLBNUM+3
  - bad INVTLB or NOP: 1
- A new operation can be accepted in the cycle after `done`.
- `reset` mid-operation: state returns to IDLE at that edge. The interrupted operation never produces a `done`, and all write strobes are 0 from the next cycle. Writes already performed remain.
- `fill_ptr` wraps modulo TLBNUM.

## Configuration
- `TLB_FILL_LFSR_EN` defined: `fill_ptr` is an IW-bit maximal-length Galois LFSR.
  - Seed is 1.
  - It advances every cycle whether or not the controller is busy.
  - It never takes the value 0, so entry 0 is never chosen by FILL.
- `TLB_FILL_LFSR_EN` undefined: `fill_ptr` is a round-robin counter that starts at 0 and increments by 1 only at each FILL write.

## Test plan
- Reset, then SRCH with `s1_found`=1, `s1_index`=5 -> `done` at cycle 2 with `srch_hit`=1, `srch_index`=5; `s1_asid` equals `csr_asid` in cycle 1.
- RD with `csr_idx`=3 and entry 3 E=1 -> `tlb_r_index`=3 in cycle 1, `rd_e`=1 with `done` at cycle 3.
- WR with `csr_idx`=7, `csr_ne`=1 -> exactly one `tlb_we` pulse with index 7 and `tlb_w_e`=0.
- Without macro, three FILLs back to back -> `tlb_w_index` values 0, 1, 2; after 16 FILLs the index wraps to 0.
- INVTLB op 5, asid 0x12, vppn 0x100, with entries 2 (G=0, match) and 9 (G=1, match) -> only index 2 cleared, `done` at cycle 19 (TLBNUM=16).
- INVTLB op 7 -> `inv_err`=1 with `done` at cycle 1 and no strobes. Separately, assert `reset` during an INVTLB scan at cycle 6 -> no `done`, `op_ready`=1 in the next cycle.
